// File: rtl/ex_pkg.sv
// Shared types for the EX stage: ALU/mult-div encodings, engine state and
// the control halves of the ID/EX and EX/MEM pipeline registers.
package ex_pkg;

    localparam int MD_CYCLES_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MF_ALU = 2'b00,
        MF_HI  = 2'b01,
        MF_LO  = 2'b10
    } mf_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic       valid;
        alu_op_e    alu_op;
        logic       md_start;
        mf_sel_e    mf_sel;
        logic       use_imm;
        logic [4:0] shamt;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } idex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } exmem_ctrl_t;

endpackage

// File: rtl/mult_div_iterativo.sv
// Iterative mult/div engine: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, sign fix-up folded into the HI/LO write.
module mult_div_iterativo
    import ex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output md_state_e        state,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

    md_state_e        state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, low, opnd, dividend;
    logic             is_div, neg_q, neg_r, div_zero;

    logic             start_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]     add_sum, shifted, trial;
    logic [WIDTH-1:0]   step_acc, step_low, quo, rem, hi_fin, lo_fin;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Handshake: start is a one-cycle request sampled at the edge the op
    // enters ID/EX; it is only accepted while IDLE or on the last BUSY cycle.
    // last marks the edge at which HI/LO are written and the engine frees up.
    assign start_div = op[1];
    assign a_neg     = !op[0] && a[WIDTH-1];
    assign b_neg     = !op[0] && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign last = (state == MD_BUSY) && (cnt == CNT_LAST);

    always_comb begin
        add_sum  = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        shifted  = {acc, low[WIDTH-1]};
        trial    = shifted - {1'b0, opnd};
        step_acc = add_sum[WIDTH:1];
        step_low = {add_sum[0], low[WIDTH-1:1]};
        if (is_div) begin
            // trial[WIDTH] is the borrow: set means the divisor did not fit
            if (!trial[WIDTH]) begin
                step_acc = trial[WIDTH-1:0];
                step_low = {low[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = shifted[WIDTH-1:0];
                step_low = {low[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod     = {step_acc, step_low};
        prod_fix = neg_q ? -prod : prod;
        quo      = neg_q ? -step_low : step_low;
        rem      = neg_r ? -step_acc : step_acc;
        hi_fin   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fin   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_fin = dividend;
                lo_fin = '1;
            end else begin
                hi_fin = rem;
                lo_fin = quo;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_BUSY;
            MD_BUSY: if (last)  state_next = start ? MD_BUSY : MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (state == MD_BUSY) begin
                cnt <= cnt + 1'b1;
                acc <= step_acc;
                low <= step_low;
                if (last) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
            end
            // A back-to-back start on the last cycle overrides the step update
            if (start) begin
                cnt      <= '0;
                acc      <= '0;
                low      <= start_div ? a_mag : b_mag;
                opnd     <= start_div ? b_mag : a_mag;
                dividend <= a;
                is_div   <= start_div;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (b == '0);
            end
        end
    end

endmodule

// File: rtl/estagio_execucao.sv
// MIPS EX stage: ID/EX register, single-cycle ALU, HI/LO read muxing,
// EX/MEM register and the stall interlock driven by the mult/div engine.
module estagio_execucao
    import ex_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [3:0]       id_alu_op,
    input  logic             id_md_start,
    input  logic [1:0]       id_md_op,
    input  logic [1:0]       id_mf_sel,
    input  logic             id_use_imm,
    input  logic [4:0]       id_shamt,
    input  logic [WIDTH-1:0] id_reg_a,
    input  logic [WIDTH-1:0] id_reg_b,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    output logic             ex_stall,
    output logic             exmem_valid,
    output logic [WIDTH-1:0] exmem_result,
    output logic [WIDTH-1:0] exmem_store_data,
    output logic [4:0]       exmem_rd,
    output logic             exmem_reg_write,
    output logic             exmem_mem_read,
    output logic             exmem_mem_write
);

    idex_ctrl_t       id_ctrl, idex_c;
    logic [WIDTH-1:0] idex_a, idex_b, idex_imm;
    exmem_ctrl_t      exmem_c;

    md_state_e        md_state;
    logic             md_last, take_id, md_go;
    logic [WIDTH-1:0] hi, lo, op_b, alu_y, ex_result;

    // The final BUSY cycle does not stall: its edge both retires the op
    // and captures the next ID instruction.
    assign ex_stall = (md_state == MD_BUSY) && !md_last;
    assign take_id  = id_valid && !id_flush;
    assign md_go    = !ex_stall && take_id && id_md_start;

    always_comb begin
        id_ctrl           = '0;
        id_ctrl.valid     = 1'b1;
        id_ctrl.alu_op    = alu_op_e'(id_alu_op);
        id_ctrl.md_start  = id_md_start;
        id_ctrl.mf_sel    = mf_sel_e'(id_mf_sel);
        id_ctrl.use_imm   = id_use_imm;
        id_ctrl.shamt     = id_shamt;
        id_ctrl.rd        = id_rd;
        id_ctrl.reg_write = id_reg_write;
        id_ctrl.mem_read  = id_mem_read;
        id_ctrl.mem_write = id_mem_write;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex_c   <= '0;
            idex_a   <= '0;
            idex_b   <= '0;
            idex_imm <= '0;
        end else if (!ex_stall) begin
            if (take_id) begin
                idex_c   <= id_ctrl;
                idex_a   <= id_reg_a;
                idex_b   <= id_reg_b;
                idex_imm <= id_imm;
            end else begin
                idex_c   <= '0;
                idex_a   <= '0;
                idex_b   <= '0;
                idex_imm <= '0;
            end
        end
    end

    mult_div_iterativo #(
        .WIDTH    (WIDTH),
        .MD_CYCLES(MD_CYCLES)
    ) u_md (
        .clock(clock),
        .reset(reset),
        .start(md_go),
        .op   (id_md_op),
        .a    (id_reg_a),
        .b    (id_reg_b),
        .state(md_state),
        .last (md_last),
        .hi   (hi),
        .lo   (lo)
    );

    assign op_b = idex_c.use_imm ? idex_imm : idex_b;

    always_comb begin
        alu_y = '0;
        case (idex_c.alu_op)
            ALU_ADD:  alu_y = idex_a + op_b;
            ALU_SUB:  alu_y = idex_a - op_b;
            ALU_AND:  alu_y = idex_a & op_b;
            ALU_OR:   alu_y = idex_a | op_b;
            ALU_XOR:  alu_y = idex_a ^ op_b;
            ALU_NOR:  alu_y = ~(idex_a | op_b);
            ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(idex_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, idex_a < op_b};
            ALU_SLL:  alu_y = op_b << idex_c.shamt;
            ALU_SRL:  alu_y = op_b >> idex_c.shamt;
            ALU_SRA:  alu_y = WIDTH'($signed(op_b) >>> idex_c.shamt);
            ALU_LUI:  alu_y = idex_imm << 16;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        ex_result = alu_y;
        case (idex_c.mf_sel)
            MF_HI:   ex_result = hi;
            MF_LO:   ex_result = lo;
            default: ex_result = alu_y;
        endcase
    end

    // Mult/div ops never reach MEM/WB; they only update HI/LO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exmem_c          <= '0;
            exmem_result     <= '0;
            exmem_store_data <= '0;
        end else if (idex_c.valid && !idex_c.md_start) begin
            exmem_c.valid     <= 1'b1;
            exmem_c.rd        <= idex_c.rd;
            exmem_c.reg_write <= idex_c.reg_write;
            exmem_c.mem_read  <= idex_c.mem_read;
            exmem_c.mem_write <= idex_c.mem_write;
            exmem_result      <= ex_result;
            exmem_store_data  <= idex_b;
        end else begin
            exmem_c          <= '0;
            exmem_result     <= '0;
            exmem_store_data <= '0;
        end
    end

    assign exmem_valid     = exmem_c.valid;
    assign exmem_rd        = exmem_c.rd;
    assign exmem_reg_write = exmem_c.reg_write;
    assign exmem_mem_read  = exmem_c.mem_read;
    assign exmem_mem_write = exmem_c.mem_write;

endmodule

// File: tb/tb_estagio_execucao.sv
// Directed and randomized checks of the EX stage against a behavioural
// ALU / HI-LO model built from plain arithmetic.
module tb_estagio_execucao;
    import ex_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid, id_flush, id_md_start, id_use_imm;
    logic [3:0]    id_alu_op;
    logic [1:0]    id_md_op, id_mf_sel;
    logic [4:0]    id_shamt, id_rd;
    logic [W-1:0]  id_reg_a, id_reg_b, id_imm;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          ex_stall, exmem_valid;
    logic [W-1:0]  exmem_result, exmem_store_data;
    logic [4:0]    exmem_rd;
    logic          exmem_reg_write, exmem_mem_read, exmem_mem_write;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_q[$];
    bit            exp_v_q[$];

    estagio_execucao #(.WIDTH(W), .MD_CYCLES(32)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_flush(id_flush), .id_alu_op(id_alu_op),
        .id_md_start(id_md_start), .id_md_op(id_md_op), .id_mf_sel(id_mf_sel),
        .id_use_imm(id_use_imm), .id_shamt(id_shamt),
        .id_reg_a(id_reg_a), .id_reg_b(id_reg_b), .id_imm(id_imm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_stall(ex_stall), .exmem_valid(exmem_valid), .exmem_result(exmem_result),
        .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_mem_write(exmem_mem_write)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // checking
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] imm,
                                             input logic use_imm, input logic [4:0] sh);
        logic [W-1:0] y;
        y = use_imm ? imm : b;
        case (op)
            4'd0:  return a + y;
            4'd1:  return a - y;
            4'd2:  return a & y;
            4'd3:  return a | y;
            4'd4:  return a ^ y;
            4'd5:  return ~(a | y);
            4'd6:  return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            4'd7:  return (a < y) ? 32'd1 : 32'd0;
            4'd8:  return y << sh;
            4'd9:  return y >> sh;
            4'd10: return W'($signed(y) >>> sh);
            4'd11: return imm << 16;
            default: return 32'd0;
        endcase
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: if (b == 0) return {a, 32'hFFFF_FFFF};
                   else return {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) return {a, 32'hFFFF_FFFF};
                     else return {a % b, a / b};
        endcase
    endfunction

    // drivers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        id_valid = 0; id_flush = 0; id_alu_op = 0; id_md_start = 0; id_md_op = 0;
        id_mf_sel = 0; id_use_imm = 0; id_shamt = 0; id_reg_a = 0; id_reg_b = 0;
        id_imm = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] imm, input logic use_imm, input logic [4:0] sh,
                             input logic [4:0] rd);
        drive_idle();
        id_valid = 1; id_alu_op = op; id_reg_a = a; id_reg_b = b; id_imm = imm;
        id_use_imm = use_imm; id_shamt = sh; id_rd = rd; id_reg_write = 1;
    endtask

    task automatic drive_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive_idle();
        id_valid = 1; id_md_start = 1; id_md_op = op; id_reg_a = a; id_reg_b = b;
    endtask

    task automatic drive_mf(input logic [1:0] sel, input logic [4:0] rd);
        drive_idle();
        id_valid = 1; id_mf_sel = sel; id_rd = rd; id_reg_write = 1;
    endtask

    // Issues one mult/div followed by mfhi/mflo; reports stall cycles,
    // EX/MEM valid cycles seen while the op was resident, and HI/LO.
    task automatic md_readback(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic flush_in_stall, output int stalls, output int vbad,
                               output logic [W-1:0] hi, output logic [W-1:0] lo);
        drive_md(op, a, b);
        tick();
        drive_mf(MF_HI, 5'd2);
        id_flush = flush_in_stall;
        stalls = 0;
        vbad = 0;
        while (ex_stall && stalls < 200) begin
            stalls++;
            if (exmem_valid) vbad++;
            tick();
        end
        id_flush = 0;
        tick();
        if (exmem_valid) vbad++;
        drive_mf(MF_LO, 5'd3);
        tick();
        hi = exmem_result;
        drive_idle();
        tick();
        lo = exmem_result;
    endtask

    initial begin
        int            stalls, vbad, total;
        logic [W-1:0]  hi, lo, ea, eb, eimm, got;
        logic [63:0]   hl;
        logic [3:0]    op;
        logic [1:0]    mop;
        logic [4:0]    sh;
        logic          ui, v, fl;

        // reset
        drive_idle();
        #1 reset = 1;
        #2;
        check("reset_stall", W'(ex_stall), 32'd0);
        check("reset_valid", W'(exmem_valid), 32'd0);
        check("reset_result", exmem_result, 32'd0);
        tick();
        reset = 0;
        tick();

        // add then sub
        drive_alu(ALU_ADD, 32'd7, 32'd10, 32'd0, 1'b0, 5'd0, 5'd4);
        tick();
        drive_alu(ALU_SUB, 32'd7, 32'd10, 32'd0, 1'b0, 5'd0, 5'd5);
        tick();
        check("add_result", exmem_result, 32'd17);
        check("add_reg_write", W'(exmem_reg_write), 32'd1);
        check("add_rd", W'(exmem_rd), 32'd4);
        drive_idle();
        tick();
        check("sub_result", exmem_result, 32'hFFFF_FFFD);
        check("sub_valid", W'(exmem_valid), 32'd1);

        // mult -3 x 5
        md_readback(MD_MULT, -32'sd3, 32'd5, 1'b0, stalls, vbad, hi, lo);
        check("mult_stall", W'(stalls), 32'd31);
        check("mult_no_valid", W'(vbad), 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // div -7/2, divu 7/0, div min/-1
        md_readback(MD_DIV, -32'sd7, 32'd2, 1'b0, stalls, vbad, hi, lo);
        check("div_stall", W'(stalls), 32'd31);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        md_readback(MD_DIVU, 32'd7, 32'd0, 1'b0, stalls, vbad, hi, lo);
        check("divu0_stall", W'(stalls), 32'd31);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd7);
        md_readback(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, stalls, vbad, hi, lo);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'd0);

        // flush a valid lw, then an unflushed lw for contrast
        drive_alu(ALU_ADD, 32'h100, 32'd0, 32'd4, 1'b1, 5'd0, 5'd8);
        id_mem_read = 1;
        id_flush = 1;
        tick();
        drive_idle();
        tick();
        check("flush_valid", W'(exmem_valid), 32'd0);
        check("flush_mem_read", W'(exmem_mem_read), 32'd0);
        drive_alu(ALU_ADD, 32'h100, 32'd0, 32'd4, 1'b1, 5'd0, 5'd8);
        id_mem_read = 1;
        tick();
        drive_idle();
        tick();
        check("lw_mem_read", W'(exmem_mem_read), 32'd1);
        check("lw_addr", exmem_result, 32'h104);

        // flush during stall is ignored
        md_readback(MD_MULTU, 32'd6, 32'd7, 1'b1, stalls, vbad, hi, lo);
        check("flush_stall_cycles", W'(stalls), 32'd31);
        check("flush_stall_lo", lo, 32'd42);
        check("flush_stall_hi", hi, 32'd0);

        // reset in the middle of a mult
        drive_md(MD_MULT, 32'd100, 32'd200);
        tick();
        drive_mf(MF_HI, 5'd2);
        repeat (15) tick();
        reset = 1;
        #1;
        check("midreset_stall", W'(ex_stall), 32'd0);
        check("midreset_valid", W'(exmem_valid), 32'd0);
        tick();
        reset = 0;
        tick();
        drive_mf(MF_LO, 5'd3);
        tick();
        check("midreset_hi", exmem_result, 32'd0);
        drive_alu(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 5'd9);
        tick();
        check("midreset_lo", exmem_result, 32'd0);
        drive_idle();
        tick();
        check("midreset_add", exmem_result, 32'd7);

        // multu 0xFFFFFFFF x 2 alone, then back-to-back with 3 x 3
        md_readback(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, stalls, vbad, hi, lo);
        check("multu_big_hi", hi, 32'd1);
        check("multu_big_lo", lo, 32'hFFFF_FFFE);
        drive_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        tick();
        drive_md(MD_MULTU, 32'd3, 32'd3);
        total = 0;
        while (ex_stall && total < 300) begin total++; tick(); end
        tick();
        drive_mf(MF_HI, 5'd2);
        while (ex_stall && total < 300) begin total++; tick(); end
        tick();
        drive_mf(MF_LO, 5'd3);
        tick();
        check("b2b_hi", exmem_result, 32'd0);
        drive_idle();
        tick();
        check("b2b_lo", exmem_result, 32'd9);
        check("b2b_total_stall", W'(total), 32'd62);

        // random ALU stream through the scoreboard
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            ea = $urandom; eb = $urandom; eimm = $urandom;
            ui = 1'($urandom_range(0, 1));
            sh = 5'($urandom_range(0, 31));
            v  = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 9) == 0);
            drive_alu(op, ea, eb, eimm, ui, sh, 5'(i));
            id_valid = v;
            id_flush = fl;
            exp_v_q.push_back(v && !fl);
            exp_q.push_back(ref_alu(op, ea, eb, eimm, ui, sh));
            tick();
            if (exp_v_q.size() > 1) begin
                v = exp_v_q.pop_front();
                got = exp_q.pop_front();
                check("rnd_valid", W'(exmem_valid), W'(v));
                if (v) check("rnd_result", exmem_result, got);
            end
        end
        drive_idle();
        tick();
        v = exp_v_q.pop_front();
        got = exp_q.pop_front();
        check("rnd_valid_last", W'(exmem_valid), W'(v));
        if (v) check("rnd_result_last", exmem_result, got);

        // random mult/div against 64-bit arithmetic
        for (int i = 0; i < 8; i++) begin
            mop = 2'($urandom_range(0, 3));
            ea = $urandom;
            eb = (i == 0) ? 32'd0 : $urandom;
            if (i == 1) begin ea = -32'sd1000; eb = 32'd7; end
            hl = ref_md(mop, ea, eb);
            md_readback(mop, ea, eb, 1'b0, stalls, vbad, hi, lo);
            check("rnd_md_stall", W'(stalls), 32'd31);
            check("rnd_md_hi", hi, hl[63:32]);
            check("rnd_md_lo", lo, hl[31:0]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/estagio_execucao.md
Name: estagio_execucao

Overview:
- EX stage of the 5-stage MIPS pipeline, directly downstream of ID decode.
- Holds the ID/EX pipeline register and a single-cycle ALU.
- Contains a multi-cycle iterative multiply/divide engine with HI/LO registers.
- Drives the EX/MEM outputs and an `ex_stall` interlock back to the hazard logic, which freezes PC and IF/ID.

Parameters:
WIDTH, 32, datapath width
MD_CYCLES, 32, iterations per mult/div; equals occupancy of a mult/div op in EX

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_flush  in  1  capture a bubble instead of the ID instruction
id_alu_op  in  4  ALU operation (package enum)
id_md_start  in  1  instruction is mult/multu/div/divu
id_md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
id_mf_sel  in  2  00 ALU result, 01 mfhi, 10 mflo
id_use_imm  in  1  operand B = id_imm
id_shamt  in  5  shift amount
id_reg_a  in  WIDTH  rs value (already forwarded)
id_reg_b  in  WIDTH  rt value (already forwarded)
id_imm  in  WIDTH  sign-extended immediate
id_rd  in  5  destination register
id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
ex_stall  out  1  hold PC, IF/ID and ID inputs this cycle
exmem_valid  out  1  EX/MEM holds a real instruction
exmem_result  out  WIDTH  ALU / HI / LO result
exmem_store_data  out  WIDTH  rt value for sw
exmem_rd  out  5  destination register
exmem_reg_write, exmem_mem_read, exmem_mem_write  out  1 each  control bits

Behaviour:
- Reset: all of the following clear to 0 immediately, asynchronously:
  - ID/EX register, EX/MEM outputs, HI, LO, iteration counter, ex_stall.
  - An in-flight mult/div is abandoned; HI/LO remain 0.
- ID/EX capture, at each edge with ex_stall=0:
  - id_flush=1 or id_valid=0: load a bubble (valid and all control bits 0).
  - Otherwise: load all id_* inputs.
  - When ex_stall=1, ID/EX holds its contents and id_flush is ignored.
- EX/MEM update, one cycle latency from ID/EX:
  - Non-mult/div instruction: exmem_* loads the instruction's result and control.
  - Mult/div instruction: exmem loads a bubble every cycle it is resident. Mult/div never writes the GPR file.
- ALU, combinational on ID/EX contents:
  - Operations: add, sub, and, or, xor, nor, slt (signed), sltu, sll, srl, sra (by shamt), lui (imm<<16).
  - Operand B = imm if use_imm, else reg_b.
  - add/sub wrap modulo 2^WIDTH; no overflow trap.
  - mf_sel selects ALU, HI or LO as the result.
- Mult/div engine, FSM IDLE/BUSY:
  - Edge E0 latches a mult/div into ID/EX: counter=0, state BUSY, operands copied into the engine.
  - One shift-add (mult) or restoring-subtract (div) step per cycle.
  - Signed variants operate on magnitudes and fix the sign at the end.
  - ex_stall = BUSY && counter != MD_CYCLES-1, so stall is high for MD_CYCLES-1 cycles.
  - At edge E0+MD_CYCLES:
    - mult: HI:LO = 64-bit product.
    - div: LO = quotient, HI = remainder; remainder takes the dividend's sign.
    - State returns to IDLE and the next ID instruction is captured at the same edge.
  - An mfhi/mflo captured at that edge reads the new HI/LO; no extra interlock is needed.
  - Divide by zero: same latency; LO = all ones, HI = dividend.
  - div of 0x80000000 by -1: LO = 0x80000000, HI = 0.
- Back-to-back mult/div: the second is captured at E0+MD_CYCLES and starts a fresh BUSY immediately.

Decomposition:
- Package `ex_pkg`:
  - ALU op enum, md_op enum, mf_sel encoding.
  - Default MD_CYCLES.
  - ID/EX and EX/MEM struct typedefs.
- Sub-module `mult_div_iterativo` contains:
  - Iteration counter and FSM.
  - Partial product/remainder registers.
  - HI/LO registers, start/done handshake.
- `estagio_execucao` keeps the pipeline registers, the ALU, and the stall and result muxing.

Test Plan:
- add then sub, reg_a=7, reg_b=10:
  - Expect exmem_result 17, then 0xFFFFFFFD, each one cycle after capture.
  - Expect exmem_reg_write=1.
- mult -3×5, then mfhi, then mflo:
  - Expect ex_stall high for exactly 31 cycles.
  - Expect mfhi result 0xFFFFFFFF and mflo result 0xFFFFFFF1.
  - Expect no exmem_valid during the mult.
- div -7/2 and divu 7/0:
  - div: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu: LO=0xFFFFFFFF, HI=7.
  - Both finish in 32 cycles.
- id_flush=1 with a valid lw in ID:
  - Expect a bubble next cycle: exmem_valid=0, mem_read=0.
  - Repeat with id_flush=1 during ex_stall: flush ignored, held instruction preserved.
- Assert reset at counter=15 of a mult:
  - Expect ex_stall=0, HI=LO=0, exmem_valid=0 immediately.
  - After release, a new add completes normally.
- Back-to-back multu 0xFFFFFFFF×2 then multu 3×3:
  - After the first: HI=1, LO=0xFFFFFFFE.
  - Total stall 62 cycles; final LO=9, HI=0.
